// File: rtl/axis_data_to_string.sv
// Purpose : renders each AXI-Stream input beat (tdata, tdest, tuser) as an ASCII hex string
//           "<DP>data<DL><EP>dest<DL><UP>user<TERM>" on an 8-bit AXI-Stream output.
// Latency : first character is valid on the edge after the input handshake, then one per output handshake.
// Backpressure: s_axis_tready is low for the whole string; m_axis_* hold while m_axis_tready is low.
// Ports   : aclk/arstn (async active-low), s_axis_tdata/tuser/tdest/tvalid/tready in,
//           m_axis_tdata/tvalid/tready out (8-bit characters, no tlast).
module axis_data_to_string #(
    parameter logic [7:0]              DELIMITER   = 8'h3B,
    parameter logic [7:0]              TERMINATION = 8'h0A,
    parameter int                      SBUS_WIDTH  = 1,
    parameter int                      USER_WIDTH  = 4,
    parameter int                      DEST_WIDTH  = 4,
    parameter int                      PREFIX_LEN  = 1,
    parameter logic [PREFIX_LEN*8-1:0] DATA_PREFIX = "#",
    parameter logic [PREFIX_LEN*8-1:0] DEST_PREFIX = "&",
    parameter logic [PREFIX_LEN*8-1:0] USER_PREFIX = "*"
) (
    input  logic                    aclk,
    input  logic                    arstn,
    input  logic [SBUS_WIDTH*8-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int DATA_W = SBUS_WIDTH * 8;
    localparam int DD     = SBUS_WIDTH * 2;        // data hex digits
    localparam int ED     = (DEST_WIDTH + 3) / 4;  // dest hex digits
    localparam int UD     = (USER_WIDTH + 3) / 4;  // user hex digits
    localparam int P      = PREFIX_LEN;

    // Start index of each segment within the string.
    localparam int A1      = P;          // data digits
    localparam int A2      = A1 + DD;    // first delimiter
    localparam int A3      = A2 + 1;     // dest prefix
    localparam int A4      = A3 + P;     // dest digits
    localparam int A5      = A4 + ED;    // second delimiter
    localparam int A6      = A5 + 1;     // user prefix
    localparam int A7      = A6 + P;     // user digits
    localparam int A8      = A7 + UD;    // termination
    localparam int STR_LEN = A8 + 1;
    localparam int CNT_W   = $clog2(STR_LEN + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return {4'h0, n} + 8'h30;
        else           return {4'h0, n} + 8'h37;
    endfunction

    // Character at position idx of the string built from the given fields.
    function automatic logic [7:0] char_at(
        input logic [CNT_W-1:0]      idx,
        input logic [DATA_W-1:0]     d,
        input logic [DEST_WIDTH-1:0] de,
        input logic [USER_WIDTH-1:0] us
    );
        logic [DD*4-1:0] d_ext;
        logic [ED*4-1:0] e_ext;
        logic [UD*4-1:0] u_ext;
        logic [7:0]      c;
        int              i;
        d_ext = d;
        e_ext = '0;
        e_ext[DEST_WIDTH-1:0] = de;
        u_ext = '0;
        u_ext[USER_WIDTH-1:0] = us;
        i = int'(idx);
        c = TERMINATION;
        if      (i < A1) c = DATA_PREFIX[(P-1-i)*8 +: 8];
        else if (i < A2) c = hex_char(d_ext[(DD-1-(i-A1))*4 +: 4]);
        else if (i < A3) c = DELIMITER;
        else if (i < A4) c = DEST_PREFIX[(P-1-(i-A3))*8 +: 8];
        else if (i < A5) c = hex_char(e_ext[(ED-1-(i-A4))*4 +: 4]);
        else if (i < A6) c = DELIMITER;
        else if (i < A7) c = USER_PREFIX[(P-1-(i-A6))*8 +: 8];
        else if (i < A8) c = hex_char(u_ext[(UD-1-(i-A7))*4 +: 4]);
        return c;
    endfunction

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;     // index of the next character to load
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic [7:0]            m_dat_q, m_dat_d;
    logic                  m_vld_q, m_vld_d;
    logic                  s_rdy_q, s_rdy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dest_d  = dest_q;
        user_d  = user_q;
        m_dat_d = m_dat_q;
        m_vld_d = m_vld_q;
        s_rdy_d = s_rdy_q;
        case (state_q)
            ST_IDLE: begin
                // Ready comes up on the first edge out of reset.
                s_rdy_d = 1'b1;
                if (s_axis_tvalid && s_rdy_q) begin
                    data_d  = s_axis_tdata;
                    dest_d  = s_axis_tdest;
                    user_d  = s_axis_tuser;
                    m_dat_d = char_at('0, s_axis_tdata, s_axis_tdest, s_axis_tuser);
                    m_vld_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    s_rdy_d = 1'b0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (m_vld_q && m_axis_tready) begin
                    // cnt_q == STR_LEN means the termination byte just went out.
                    if (cnt_q == CNT_W'(STR_LEN)) begin
                        m_vld_d = 1'b0;
                        s_rdy_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        m_dat_d = char_at(cnt_q, data_q, dest_q, user_q);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            user_q  <= '0;
            m_dat_q <= 8'h00;
            m_vld_q <= 1'b0;
            s_rdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
            m_dat_q <= m_dat_d;
            m_vld_q <= m_vld_d;
            s_rdy_q <= s_rdy_d;
        end
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tvalid = m_vld_q;

endmodule

// File: tb/tb_axis_data_to_string.sv
module tb_axis_data_to_string;

    logic       aclk = 1'b0;
    logic       arstn;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [3:0] s_axis_tuser;
    logic [3:0] s_axis_tdest;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_cnt  = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    axis_data_to_string dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdest  (s_axis_tdest),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the expected text for a beat with the default parameters.
    function automatic string model(input logic [7:0] d, input logic [3:0] de, input logic [3:0] u);
        string s;
        s = $sformatf("#%02h;&%01h;*%01h\n", d, de, u);
        return s.toupper();
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [3:0] de, input logic [3:0] u, input string tag);
        int n;
        s_axis_tdata  = d;
        s_axis_tdest  = de;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis_tready) chk({tag, ":accept_timeout"}, 32'(s_axis_tready), 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        // Fields wander after the handshake; the string in flight must not change.
        s_axis_tdata  = 8'($urandom);
        s_axis_tdest  = 4'($urandom);
        s_axis_tuser  = 4'($urandom);
    endtask

    // Consumes one string; returns at the negedge after the edge where its last byte handshaked.
    task automatic recv(input string exp, input bit rnd, input bit lat, input string tag, output int term_cyc);
        int         got;
        int         n;
        logic [7:0] prev;
        bit         hold;
        got = 0; n = 0; hold = 0; prev = 8'h00; term_cyc = 0;
        while (got < exp.len() && n < 400) begin
            if (lat && n == 0) chk({tag, ":latency_vld"}, 32'(m_axis_tvalid), 32'd1);
            if (hold) begin
                chk({tag, ":hold_vld"}, 32'(m_axis_tvalid), 32'd1);
                chk({tag, ":hold_dat"}, 32'(m_axis_tdata), 32'(prev));
            end
            if (m_axis_tvalid) chk({tag, ":s_rdy_low"}, 32'(s_axis_tready), 32'd0);
            if (!rnd && got > 0) chk({tag, ":no_bubble"}, 32'(m_axis_tvalid), 32'd1);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = 0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    chk($sformatf("%s:byte%0d", tag, got), 32'(m_axis_tdata), 32'(exp[got]));
                    if (got == exp.len() - 1) term_cyc = cyc_cnt + 1;
                    got++;
                end else begin
                    hold = 1;
                    prev = m_axis_tdata;
                end
            end
            @(negedge aclk);
            n++;
        end
        if (got < exp.len()) chk({tag, ":recv_timeout"}, 32'(got), 32'(exp.len()));
    endtask

    task automatic do_str(input logic [7:0] d, input logic [3:0] de, input logic [3:0] u,
                          input bit rnd, input string tag);
        int tc;
        send(d, de, u, tag);
        recv(model(d, de, u), rnd, 1'b1, tag, tc);
        chk({tag, ":end_vld"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, ":end_s_rdy"}, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        int term1, term2, acc2;
        arstn         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tdest  = 4'h0;
        s_axis_tuser  = 4'h0;
        m_axis_tready = 1'b0;

        // Reset values and release.
        #1;
        chk("rst_m_vld", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_dat", 32'(m_axis_tdata), 32'h00);
        chk("rst_s_rdy", 32'(s_axis_tready), 32'd0);
        repeat (3) @(negedge aclk);
        arstn = 1'b1;
        #1;
        chk("rel_s_rdy_before_edge", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        chk("rel_s_rdy", 32'(s_axis_tready), 32'd1);
        chk("rel_m_vld", 32'(m_axis_tvalid), 32'd0);
        chk("rel_m_dat", 32'(m_axis_tdata), 32'h00);

        // Directed strings with the sink always ready.
        do_str(8'hA5, 4'h7, 4'h3, 1'b0, "a5");
        do_str(8'h00, 4'h0, 4'h0, 1'b0, "zeros");
        do_str(8'hFF, 4'hF, 4'hF, 1'b0, "ones");

        // Same beat with a stuttering sink.
        do_str(8'hA5, 4'h7, 4'h3, 1'b1, "a5_bp");

        // Random beats, random backpressure.
        for (int k = 0; k < 6; k++) begin
            do_str(8'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", k));
        end

        // Source holds valid across two beats.
        acc2 = 0;
        fork
            begin
                int n;
                s_axis_tdata = 8'h12; s_axis_tdest = 4'h1; s_axis_tuser = 4'h2;
                s_axis_tvalid = 1'b1;
                n = 0;
                while (!s_axis_tready && n < 100) begin @(negedge aclk); n++; end
                @(negedge aclk);
                s_axis_tdata = 8'h9C; s_axis_tdest = 4'hE; s_axis_tuser = 4'hB;
                n = 0;
                while (!s_axis_tready && n < 100) begin @(negedge aclk); n++; end
                acc2 = cyc_cnt + 1;
                @(negedge aclk);
                s_axis_tvalid = 1'b0;
            end
            begin
                recv(model(8'h12, 4'h1, 4'h2), 1'b0, 1'b0, "b2b_1", term1);
                recv(model(8'h9C, 4'hE, 4'hB), 1'b0, 1'b0, "b2b_2", term2);
            end
        join
        chk("b2b_accept_after_term", 32'(acc2), 32'(term1 + 1));
        chk("b2b_end_vld", 32'(m_axis_tvalid), 32'd0);

        // Reset in the middle of a string.
        send(8'h3C, 4'h2, 4'h9, "abort");
        m_axis_tready = 1'b1;
        repeat (4) @(negedge aclk);
        chk("abort_mid_vld", 32'(m_axis_tvalid), 32'd1);
        arstn = 1'b0;
        #1;
        chk("abort_rst_vld", 32'(m_axis_tvalid), 32'd0);
        chk("abort_rst_dat", 32'(m_axis_tdata), 32'h00);
        chk("abort_rst_s_rdy", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        arstn = 1'b1;
        @(negedge aclk);
        chk("abort_rel_s_rdy", 32'(s_axis_tready), 32'd1);
        chk("abort_rel_vld", 32'(m_axis_tvalid), 32'd0);
        do_str(8'h5A, 4'h0, 4'h1, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
